// File: rtl/any1_sel_align.sv
// Memory request to bus beat aligner: emits bus-aligned address, shifted byte-lane select and rotate amount.
// ANY1_SEL_UNALIGNED_EN: when defined, bus-crossing requests split into two beats; otherwise they are rejected.
module any1_sel_align #(
  parameter int BUS_BYTES = 32,
  parameter int ADDR_W    = 32,
  parameter int SZ_W      = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [ADDR_W-1:0]             req_adr_i,
  input  logic [SZ_W-1:0]               req_size_i,
  output logic                          beat_valid_o,
  input  logic                          beat_ready_i,
  output logic [ADDR_W-1:0]             beat_adr_o,
  output logic [BUS_BYTES-1:0]          beat_sel_o,
  output logic [$clog2(BUS_BYTES)-1:0]  beat_shift_o,
  output logic                          beat_num_o,
  output logic                          beat_last_o,
  output logic                          err_o
);
  localparam int OFS_W = $clog2(BUS_BYTES);
  localparam logic [2*BUS_BYTES-1:0] ONE_W = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_B0   = 2'd1,
    S_B1   = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // beat outputs stay frozen while valid is high and ready is low.
  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       adr_q, adr_d;
  logic [BUS_BYTES-1:0]    sel_q, sel_d;
  logic [OFS_W-1:0]        shift_q, shift_d;
  logic                    err_q, err_d;
`ifdef ANY1_SEL_UNALIGNED_EN
  logic                    num_q, num_d;
  logic                    last_q, last_d;
  logic [BUS_BYTES-1:0]    hi_q, hi_d;
`endif

  logic [OFS_W-1:0]        ofs;
  logic [31:0]             nb;
  logic                    size_ok;
  logic [2*BUS_BYTES-1:0]  wide;
  logic                    crossing;
  logic                    bad;
  logic                    fire;
  logic                    accept;

  // Request decode: lane mask positioned at the address offset within a two-bus-wide window.
  always_comb begin
    ofs      = req_adr_i[OFS_W-1:0];
    size_ok  = (32'(req_size_i) <= 32'(OFS_W));
    nb       = size_ok ? (32'd1 << req_size_i) : 32'd1;
    wide     = ((ONE_W << nb) - ONE_W) << ofs;
    crossing = |wide[2*BUS_BYTES-1:BUS_BYTES];
`ifdef ANY1_SEL_UNALIGNED_EN
    bad      = !size_ok;
`else
    // A naturally aligned legal request can never cross, so crossing only adds redundancy here.
    bad      = !size_ok | (|(ofs & OFS_W'(nb - 32'd1))) | crossing;
`endif
  end

  assign beat_valid_o = (state_q != S_IDLE);
  assign beat_adr_o   = adr_q;
  assign beat_sel_o   = sel_q;
  assign beat_shift_o = shift_q;
  assign err_o        = err_q;
`ifdef ANY1_SEL_UNALIGNED_EN
  assign beat_num_o   = num_q;
  assign beat_last_o  = last_q;
`else
  assign beat_num_o   = 1'b0;
  assign beat_last_o  = 1'b1;
`endif

  assign fire        = beat_valid_o & beat_ready_i;
  assign req_ready_o = (state_q == S_IDLE) | (fire & beat_last_o);
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    shift_d = shift_q;
    err_d   = 1'b0;
`ifdef ANY1_SEL_UNALIGNED_EN
    num_d   = num_q;
    last_d  = last_q;
    hi_d    = hi_q;
`endif
    if (fire) begin
`ifdef ANY1_SEL_UNALIGNED_EN
      if (state_q == S_B0 && !last_q) begin
        state_d = S_B1;
        adr_d   = adr_q + ADDR_W'(BUS_BYTES);
        sel_d   = hi_q;
        num_d   = 1'b1;
        last_d  = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
`else
      state_d = S_IDLE;
`endif
    end
    // A new request may land in the same cycle the last beat leaves.
    if (accept) begin
      if (bad) begin
        err_d = 1'b1;
      end else begin
        state_d = S_B0;
        adr_d   = {req_adr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        sel_d   = wide[BUS_BYTES-1:0];
        shift_d = ofs;
`ifdef ANY1_SEL_UNALIGNED_EN
        num_d   = 1'b0;
        last_d  = !crossing;
        hi_d    = wide[2*BUS_BYTES-1:BUS_BYTES];
`endif
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      sel_q   <= '0;
      shift_q <= '0;
      err_q   <= 1'b0;
`ifdef ANY1_SEL_UNALIGNED_EN
      num_q   <= 1'b0;
      last_q  <= 1'b0;
      hi_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      shift_q <= shift_d;
      err_q   <= err_d;
`ifdef ANY1_SEL_UNALIGNED_EN
      num_q   <= num_d;
      last_q  <= last_d;
      hi_q    <= hi_d;
`endif
    end
  end
endmodule

// File: tb/tb_any1_sel_align.sv
// Bench for any1_sel_align: directed requests, expected beats queued and checked by a monitor.
module tb_any1_sel_align;
  localparam int BUS_BYTES = 32;
  localparam int ADDR_W    = 32;
  localparam int SZ_W      = 3;
  localparam int OFS_W     = 5;
  localparam int W         = ADDR_W + BUS_BYTES + OFS_W + 2;
`ifdef ANY1_SEL_UNALIGNED_EN
  localparam logic LAST_RST = 1'b0;
`else
  localparam logic LAST_RST = 1'b1;
`endif

  logic                 clk_i;
  logic                 rst_i;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [ADDR_W-1:0]    req_adr_i;
  logic [SZ_W-1:0]      req_size_i;
  logic                 beat_valid_o;
  logic                 beat_ready_i;
  logic [ADDR_W-1:0]    beat_adr_o;
  logic [BUS_BYTES-1:0] beat_sel_o;
  logic [OFS_W-1:0]     beat_shift_o;
  logic                 beat_num_o;
  logic                 beat_last_o;
  logic                 err_o;

  any1_sel_align #(.BUS_BYTES(BUS_BYTES), .ADDR_W(ADDR_W), .SZ_W(SZ_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_adr_i(req_adr_i), .req_size_i(req_size_i),
    .beat_valid_o(beat_valid_o), .beat_ready_i(beat_ready_i),
    .beat_adr_o(beat_adr_o), .beat_sel_o(beat_sel_o), .beat_shift_o(beat_shift_o),
    .beat_num_o(beat_num_o), .beat_last_o(beat_last_o), .err_o(err_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [W-1:0] exp_q[$];
  int           err_exp;
  int           checks;
  int           errors;
  logic [W-1:0] mon_act;
  logic [W-1:0] mon_exp;

  function automatic logic [W-1:0] mk(input logic [31:0] adr, input logic [31:0] sel,
                                      input logic [4:0] sh, input logic num, input logic last);
    return {adr, sel, sh, num, last};
  endfunction

  function automatic logic [W-1:0] act_beat();
    return {beat_adr_o, beat_sel_o, beat_shift_o, beat_num_o, beat_last_o};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (beat_valid_o && beat_ready_i) begin
        mon_act = act_beat();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got %0h expected none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          check("beat", mon_act, mon_exp);
        end
      end
      if (err_o) begin
        checks++;
        if (err_exp == 0) begin
          errors++;
          $display("FAIL err_unexpected: got 1 expected 0");
        end else begin
          err_exp--;
        end
      end
    end
  end

  // driver tasks
  task automatic send(input logic [31:0] adr, input logic [2:0] sz, output int waits);
    req_adr_i   = adr;
    req_size_i  = sz;
    req_valid_i = 1'b1;
    waits = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      waits++;
      if (req_ready_o) break;
    end
    if (!req_ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready 0 expected 1");
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && err_exp == 0 && !beat_valid_o) break;
    end
    check("drain_beats", exp_q.size(), 0);
    check("drain_errs", err_exp, 0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [31:0] adr, input logic [2:0] sz, input logic bad,
                     input logic [W-1:0] e0, input logic two, input logic [W-1:0] e1);
    int w;
    if (bad) err_exp++;
    else begin
      exp_q.push_back(e0);
      if (two) exp_q.push_back(e1);
    end
    send(adr, sz, w);
    idle();
    drain();
  endtask

  initial begin
    int w;
    int w2;
    logic [W-1:0] stall_exp;
    checks = 0; errors = 0; err_exp = 0;
    rst_i = 1'b1; req_valid_i = 1'b0; beat_ready_i = 1'b1;
    req_adr_i = '0; req_size_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", req_ready_o, 1);
    check("rst_valid", beat_valid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_beat", act_beat(), mk(32'h0, 32'h0, 5'd0, 1'b0, LAST_RST));
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // single aligned word, one-cycle latency, ready returns after it leaves
    exp_q.push_back(mk(32'h1000, 32'h0000_00F0, 5'd4, 1'b0, 1'b1));
    send(32'h1004, 3'd2, w);
    idle();
    check("lat_valid", beat_valid_o, 1);
    @(posedge clk_i);
    #1;
    check("ready_after", req_ready_o, 1);
    drain();

    req(32'h1008, 3'd3, 1'b0, mk(32'h1000, 32'h0000_FF00, 5'd8, 1'b0, 1'b1), 1'b0, '0);
    req(32'h2000, 3'd5, 1'b0, mk(32'h2000, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1), 1'b0, '0);
    req(32'h101F, 3'd0, 1'b0, mk(32'h1000, 32'h8000_0000, 5'd31, 1'b0, 1'b1), 1'b0, '0);
    req(32'h1000, 3'd6, 1'b1, '0, 1'b0, '0);
    req(32'h1000, 3'd7, 1'b1, '0, 1'b0, '0);
`ifdef ANY1_SEL_UNALIGNED_EN
    req(32'h101E, 3'd3, 1'b0, mk(32'h1000, 32'hC000_0000, 5'd30, 1'b0, 1'b0),
        1'b1, mk(32'h1020, 32'h0000_003F, 5'd30, 1'b1, 1'b1));
    req(32'h1002, 3'd2, 1'b0, mk(32'h1000, 32'h0000_003C, 5'd2, 1'b0, 1'b1), 1'b0, '0);
    req(32'h2004, 3'd5, 1'b0, mk(32'h2000, 32'hFFFF_FFF0, 5'd4, 1'b0, 1'b0),
        1'b1, mk(32'h2020, 32'h0000_000F, 5'd4, 1'b1, 1'b1));
    req(32'hFFFF_FFFC, 3'd3, 1'b0, mk(32'hFFFF_FFE0, 32'hF000_0000, 5'd28, 1'b0, 1'b0),
        1'b1, mk(32'h0000_0000, 32'h0000_000F, 5'd28, 1'b1, 1'b1));
    stall_exp = mk(32'h1000, 32'hC000_0000, 5'd30, 1'b0, 1'b0);
    exp_q.push_back(stall_exp);
    exp_q.push_back(mk(32'h1020, 32'h0000_003F, 5'd30, 1'b1, 1'b1));
    beat_ready_i = 1'b0;
    send(32'h101E, 3'd3, w);
`else
    req(32'h1002, 3'd2, 1'b1, '0, 1'b0, '0);
    req(32'h101E, 3'd3, 1'b1, '0, 1'b0, '0);
    req(32'h2004, 3'd5, 1'b1, '0, 1'b0, '0);
    stall_exp = mk(32'h1000, 32'h0000_FF00, 5'd8, 1'b0, 1'b1);
    exp_q.push_back(stall_exp);
    beat_ready_i = 1'b0;
    send(32'h1008, 3'd3, w);
`endif
    // stalled beat must hold and block new requests
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("stall_beat", act_beat(), stall_exp);
      check("stall_ready", req_ready_o, 0);
      @(posedge clk_i);
      #1;
    end
    beat_ready_i = 1'b1;
    drain();

    // illegal size: single err pulse right after the accepting edge, no beat
    err_exp++;
    send(32'h1000, 3'd6, w);
    idle();
    check("err_now", err_o, 1);
    check("err_no_beat", beat_valid_o, 0);
    @(posedge clk_i);
    #1;
    check("err_once", err_o, 0);
    drain();

    // back-to-back: second request accepted while first beat leaves
    exp_q.push_back(mk(32'h3000, 32'h0000_000F, 5'd0, 1'b0, 1'b1));
    exp_q.push_back(mk(32'h3000, 32'h00F0_0000, 5'd20, 1'b0, 1'b1));
    send(32'h3000, 3'd2, w);
    send(32'h3014, 3'd2, w2);
    idle();
    check("no_bubble_waits", w2, 1);
    check("b2b_sel", beat_sel_o, 32'h00F0_0000);
    drain();

    // reset while a request is in flight
    beat_ready_i = 1'b0;
`ifdef ANY1_SEL_UNALIGNED_EN
    exp_q.push_back(mk(32'h1000, 32'hC000_0000, 5'd30, 1'b0, 1'b0));
    send(32'h101E, 3'd3, w);
    idle();
    @(posedge clk_i);
    #1;
    beat_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    beat_ready_i = 1'b0;
    check("in_b1_num", beat_num_o, 1);
`else
    exp_q.push_back(mk(32'h1000, 32'h0000_FF00, 5'd8, 1'b0, 1'b1));
    send(32'h1008, 3'd3, w);
    idle();
    @(posedge clk_i);
    #1;
`endif
    check("held_valid", beat_valid_o, 1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_valid", beat_valid_o, 0);
    check("mid_rst_ready", req_ready_o, 1);
    check("mid_rst_beat", act_beat(), mk(32'h0, 32'h0, 5'd0, 1'b0, LAST_RST));
    exp_q.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    beat_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    req(32'h1004, 3'd2, 1'b0, mk(32'h1000, 32'h0000_00F0, 5'd4, 1'b0, 1'b1), 1'b0, '0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
